// File: rtl/hdlverifier_capture_readout.sv
// Capture-RAM readout engine: streams captured words LSB-first on tdo under TAP shift-DR control.
// The next word is prefetched while the current one shifts, so consecutive words leave no gap.
module hdlverifier_capture_readout #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  tck,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  flag_full,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  shift,
    output logic                  rd,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  tdo,
    output logic                  busy,
    output logic                  done,
    output logic                  start_err,
    output logic [15:0]           bitcount
);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [15:0]           bitcount_q, bitcount_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [DATA_WIDTH-1:0] pref_q, pref_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   word_q, word_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  pf_arm_q, pf_arm_d;
    logic                  start_err_q, start_err_d;
    logic                  last_word;

    assign last_word = (word_q == count_q - 1'b1);

    always_comb begin
        state_d     = state_q;
        rd_d        = 1'b0;
        raddr_d     = raddr_q;
        bitcount_d  = bitcount_q;
        sreg_d      = sreg_q;
        pref_d      = pref_q;
        count_d     = count_q;
        word_d      = word_q;
        bit_d       = bit_q;
        pf_arm_d    = 1'b0;
        start_err_d = 1'b0;

        // RAM answers one cycle after it samples rd; capture independently of shift
        if (pf_arm_q) begin
            pref_d = rd_data;
        end

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (flag_full && (num_words != '0)) begin
                            state_d    = ST_FETCH;
                            rd_d       = 1'b1;
                            raddr_d    = '0;
                            bitcount_d = '0;
                            count_d    = (num_words > DEPTH) ? DEPTH : num_words;
                            word_d     = '0;
                            bit_d      = '0;
                        end else begin
                            start_err_d = 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    // rd_q still high means the RAM has not answered yet
                    if (!rd_q) begin
                        sreg_d  = rd_data;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    pf_arm_d = rd_q;
                    if (shift) begin
                        sreg_d     = sreg_q >> 1;
                        bitcount_d = (bitcount_q == 16'hFFFF) ? bitcount_q : bitcount_q + 16'd1;
                        if ((bit_q == '0) && !last_word) begin
                            rd_d    = 1'b1;
                            raddr_d = raddr_q + 1'b1;
                        end
                        if (bit_q == BIT_LAST) begin
                            bit_d = '0;
                            if (last_word) begin
                                state_d = ST_DONE;
                            end else begin
                                sreg_d = pref_q;
                                word_d = word_q + 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rd_q        <= 1'b0;
            raddr_q     <= '0;
            bitcount_q  <= '0;
            sreg_q      <= '0;
            pref_q      <= '0;
            count_q     <= '0;
            word_q      <= '0;
            bit_q       <= '0;
            pf_arm_q    <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            raddr_q     <= raddr_d;
            bitcount_q  <= bitcount_d;
            sreg_q      <= sreg_d;
            pref_q      <= pref_d;
            count_q     <= count_d;
            word_q      <= word_d;
            bit_q       <= bit_d;
            pf_arm_q    <= pf_arm_d;
            start_err_q <= start_err_d;
        end
    end

    assign rd        = rd_q;
    assign raddr     = raddr_q;
    assign bitcount  = bitcount_q;
    assign start_err = start_err_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
    assign tdo       = (state_q == ST_SHIFT) && sreg_q[0];

endmodule

// File: tb/tb_hdlverifier_capture_readout.sv
// Bench for hdlverifier_capture_readout: RAM model plus scoreboard of expected read addresses and tdo bits.
module tb_hdlverifier_capture_readout;
    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          tck = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          flag_full = 1'b0;
    logic [AW:0]   num_words = '0;
    logic          shift = 1'b0;
    logic          rd;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rd_data;
    logic          tdo, busy, done, start_err;
    logic [15:0]   bitcount;

    logic [DW-1:0] mem [DEPTH];
    int            n_checks = 0;
    int            n_fail = 0;
    int            busy_cnt = 0;
    bit            exp_bits[$];
    logic [AW-1:0] exp_addr[$];

    hdlverifier_capture_readout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .tck(tck), .reset_n(reset_n), .start(start), .abort(abort),
        .flag_full(flag_full), .num_words(num_words), .shift(shift),
        .rd(rd), .raddr(raddr), .rd_data(rd_data), .tdo(tdo), .busy(busy),
        .done(done), .start_err(start_err), .bitcount(bitcount)
    );

    always #5 tck = ~tck;

    always @(posedge tck) begin
        if (rd) rd_data <= mem[raddr];
    end

    // Scoreboard monitor: every rd pops an address, every SHIFT cycle with shift=1 pops a bit
    always @(negedge tck) begin
        if (!reset_n) begin
            busy_cnt = 0;
        end else begin
            busy_cnt = busy ? busy_cnt + 1 : 0;
            if (rd) begin
                n_checks++;
                if (exp_addr.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_unexpected: rd=1 raddr=%0d, required no read", raddr);
                end else begin
                    logic [AW-1:0] a;
                    a = exp_addr.pop_front();
                    if (raddr !== a) begin
                        n_fail++;
                        $display("FAIL rd_addr: raddr=%0d required %0d", raddr, a);
                    end
                end
            end
            if (busy && busy_cnt >= 3 && shift) begin
                n_checks++;
                if (exp_bits.size() == 0) begin
                    n_fail++;
                    $display("FAIL tdo_extra: shift cycle with no expected bit, tdo=%b", tdo);
                end else begin
                    bit b;
                    b = exp_bits.pop_front();
                    if (tdo !== b) begin
                        n_fail++;
                        $display("FAIL tdo_bit: tdo=%b required %b", tdo, b);
                    end else begin
                        $display("tdo bit %b ok (%0d left)", tdo, exp_bits.size());
                    end
                end
            end
            if (!busy || busy_cnt < 3) begin
                n_checks++;
                if (tdo !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tdo_idle: tdo=%b required 0 outside SHIFT", tdo);
                end
            end
        end
    end

    task automatic push_readout(input int nw);
        int cnt;
        cnt = (nw > DEPTH) ? DEPTH : nw;
        for (int w = 0; w < cnt; w++) begin
            exp_addr.push_back(AW'(w));
            for (int b = 0; b < DW; b++) exp_bits.push_back(mem[w][b]);
        end
    endtask

    task automatic do_start(input int nw, input bit ff, input bit accept);
        @(posedge tck); #1;
        start = 1'b1;
        flag_full = ff;
        num_words = (AW+1)'(nw);
        if (accept) push_readout(nw);
        @(posedge tck); #1;
        start = 1'b0;
        $display("start nw=%0d flag_full=%b accept=%b", nw, ff, accept);
    endtask

    task automatic wait_done(input bit toggle, input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(posedge tck); #1;
            if (toggle) shift = ~shift;
            @(negedge tck);
            seen = done;
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #3;
        n_checks++;
        if ({rd, raddr, tdo, busy, done, start_err, bitcount} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: outputs=%h required 0", {rd, raddr, tdo, busy, done, start_err, bitcount});
        end
        repeat (3) @(posedge tck);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge tck);
        n_checks++;
        if ({rd, raddr, tdo, busy, done, start_err, bitcount} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: outputs=%h required 0", {rd, raddr, tdo, busy, done, start_err, bitcount});
        end
        $display("reset checked");
    endtask

    task automatic test_basic();
        bit seen;
        shift = 1'b1;
        do_start(2, 1'b1, 1'b1);
        wait_done(1'b0, 60, seen);
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL basic_done: no done within bound, required done"); end
        n_checks++;
        if (bitcount !== 16'd16 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_count: bitcount=%0d busy=%b required 16/0", bitcount, busy);
        end
        n_checks++;
        if (exp_bits.size() != 0 || exp_addr.size() != 0) begin
            n_fail++;
            $display("FAIL basic_drain: bits left=%0d reads left=%0d required 0/0", exp_bits.size(), exp_addr.size());
        end
        @(negedge tck);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: done=%b required 0 after one cycle", done); end
        $display("basic readout checked");
    endtask

    task automatic test_start_err();
        int nw_tab[2] = '{2, 0};
        bit ff_tab[2] = '{1'b0, 1'b1};
        shift = 1'b0;
        for (int i = 0; i < 2; i++) begin
            do_start(nw_tab[i], ff_tab[i], 1'b0);
            @(negedge tck);
            n_checks++;
            if (start_err !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL start_err_pulse[%0d]: start_err=%b busy=%b required 1/0", i, start_err, busy);
            end
            @(negedge tck);
            n_checks++;
            if (start_err !== 1'b0 || busy !== 1'b0 || bitcount !== 16'd16) begin
                n_fail++;
                $display("FAIL start_err_after[%0d]: start_err=%b busy=%b bitcount=%0d required 0/0/16", i, start_err, busy, bitcount);
            end
        end
    endtask

    task automatic test_toggle();
        bit seen;
        shift = 1'b0;
        do_start(2, 1'b1, 1'b1);
        flag_full = 1'b0;
        wait_done(1'b1, 120, seen);
        n_checks++;
        if (!seen || bitcount !== 16'd16 || exp_bits.size() != 0 || exp_addr.size() != 0) begin
            n_fail++;
            $display("FAIL toggle: done=%b bitcount=%0d bits left=%0d reads left=%0d required 1/16/0/0",
                     seen, bitcount, exp_bits.size(), exp_addr.size());
        end
        $display("toggled-shift readout checked");
    endtask

    task automatic test_clamp();
        bit seen;
        shift = 1'b1;
        do_start(40, 1'b1, 1'b1);
        wait_done(1'b0, 400, seen);
        n_checks++;
        if (!seen || bitcount !== 16'd256 || exp_addr.size() != 0) begin
            n_fail++;
            $display("FAIL clamp: done=%b bitcount=%0d reads left=%0d required 1/256/0", seen, bitcount, exp_addr.size());
        end
        $display("clamped readout checked");
    endtask

    task automatic test_back_to_back();
        bit seen;
        shift = 1'b1;
        do_start(2, 1'b1, 1'b1);
        @(posedge tck); #1 start = 1'b1;
        @(posedge tck); #1 start = 1'b0;
        @(negedge tck);
        n_checks++;
        if (start_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start: start_err=%b busy=%b required 0/1", start_err, busy);
        end
        wait_done(1'b0, 60, seen);
        n_checks++;
        if (!seen || bitcount !== 16'd16) begin
            n_fail++;
            $display("FAIL busy_start_done: done=%b bitcount=%0d required 1/16", seen, bitcount);
        end
        do_start(1, 1'b1, 1'b1);
        wait_done(1'b0, 40, seen);
        n_checks++;
        if (!seen || bitcount !== 16'd8 || exp_addr.size() != 0) begin
            n_fail++;
            $display("FAIL single_word: done=%b bitcount=%0d reads left=%0d required 1/8/0", seen, bitcount, exp_addr.size());
        end
    endtask

    task automatic test_abort();
        bit seen;
        shift = 1'b1;
        do_start(2, 1'b1, 1'b1);
        repeat (5) @(posedge tck);
        #1 abort = 1'b1;
        @(posedge tck); #1 abort = 1'b0;
        @(negedge tck);
        n_checks++;
        if (busy !== 1'b0 || rd !== 1'b0 || done !== 1'b0 || bitcount !== 16'd3) begin
            n_fail++;
            $display("FAIL abort: busy=%b rd=%b done=%b bitcount=%0d required 0/0/0/3", busy, rd, done, bitcount);
        end
        exp_bits.delete();
        exp_addr.delete();
        seen = 1'b0;
        repeat (20) begin
            @(negedge tck);
            if (done) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL abort_no_done: done seen=1 required 0"); end
        @(posedge tck); #1;
        abort = 1'b1; start = 1'b1; flag_full = 1'b1; num_words = 'd2;
        @(posedge tck); #1;
        abort = 1'b0; start = 1'b0;
        @(negedge tck);
        n_checks++;
        if (busy !== 1'b0 || start_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_priority: busy=%b start_err=%b required 0/0", busy, start_err);
        end
        do_start(2, 1'b1, 1'b1);
        n_checks++;
        if (bitcount !== 16'd0 || raddr !== '0 || rd !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: bitcount=%0d raddr=%0d rd=%b required 0/0/1", bitcount, raddr, rd);
        end
        wait_done(1'b0, 60, seen);
        n_checks++;
        if (!seen || bitcount !== 16'd16) begin
            n_fail++;
            $display("FAIL restart_done: done=%b bitcount=%0d required 1/16", seen, bitcount);
        end
    endtask

    task automatic test_reset_mid();
        shift = 1'b1;
        do_start(2, 1'b1, 1'b1);
        repeat (6) @(posedge tck);
        @(negedge tck);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({rd, raddr, tdo, busy, done, start_err, bitcount} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: outputs=%h required 0", {rd, raddr, tdo, busy, done, start_err, bitcount});
        end
        exp_bits.delete();
        exp_addr.delete();
        @(posedge tck); #2 reset_n = 1'b1;
        repeat (10) @(negedge tck);
        n_checks++;
        if (busy !== 1'b0 || bitcount !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_after: busy=%b bitcount=%0d required 0/0", busy, bitcount);
        end
        $display("mid-shift reset checked");
    endtask

    initial begin
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        for (int i = 2; i < DEPTH; i++) mem[i] = DW'($urandom);
        test_reset();
        test_basic();
        test_start_err();
        test_toggle();
        test_clamp();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        repeat (2) @(posedge tck);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
